// File: rtl/sync_sp_ram_ctrl_nx64.sv
// Initiator for a synchronous single-port N x 64-bit byte-enable RAM: request stream in,
// read-response stream out, with optional zero-fill after reset.
module sync_sp_ram_ctrl_nx64 #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_DEPTH  = 1024,
  parameter int RAM_LATENCY = 1,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWrEn_SI,
  input  logic [7:0]            ReqBEn_SI,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [63:0]           ReqWrData_DI,
  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic [63:0]           RspRdData_DO,
  output logic                  InitDone_SO,
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [7:0]            BEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [63:0]           WrData_DO,
  input  logic [63:0]           RdData_DI
);

  localparam int FIFO_DEPTH = RAM_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CRED_W     = $clog2(RAM_LATENCY + 3);

  typedef enum logic [1:0] {RESET_WAIT, CLEAR, RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clrCnt_q, clrCnt_d;
  logic [RAM_LATENCY-1:0]  rdPipe_q, rdPipe_d;
  logic [63:0]             fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wrPtr_q, rdPtr_q;
  logic [CRED_W-1:0]       fillCnt_q, credit_q;

  logic reqReady, accept, readAccept, push, pop;

  // Ready depends on registered state only; credits cap reads so pushes always fit.
  assign reqReady     = (state_q == RUN) && (credit_q < CRED_W'(FIFO_DEPTH));
  assign ReqReady_SO  = reqReady;
  assign accept       = ReqValid_SI & reqReady;
  assign readAccept   = accept & ~ReqWrEn_SI;
  assign push         = rdPipe_q[RAM_LATENCY-1];
  assign RspValid_SO  = (fillCnt_q != '0);
  assign pop          = RspValid_SO & RspReady_SI;
  assign RspRdData_DO = fifoMem_q[rdPtr_q];
  assign InitDone_SO  = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    clrCnt_d  = clrCnt_q;
    CSel_SO   = 1'b0;
    WrEn_SO   = 1'b0;
    BEn_SO    = '0;
    Addr_DO   = '0;
    WrData_DO = '0;
    case (state_q)
      RESET_WAIT: state_d = INIT_ZERO ? CLEAR : RUN;
      CLEAR: begin
        CSel_SO = 1'b1;
        WrEn_SO = 1'b1;
        BEn_SO  = 8'hFF;
        Addr_DO = clrCnt_q;
        if (clrCnt_q == ADDR_WIDTH'(DATA_DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          clrCnt_d = clrCnt_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        if (accept) begin
          CSel_SO   = 1'b1;
          WrEn_SO   = ReqWrEn_SI;
          BEn_SO    = ReqBEn_SI;
          Addr_DO   = ReqAddr_DI;
          WrData_DO = ReqWrData_DI;
        end
      end
      default: state_d = RESET_WAIT;
    endcase
  end

  always_comb begin
    rdPipe_d    = '0;
    rdPipe_d[0] = readAccept;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      rdPipe_d[i] = rdPipe_q[i-1];
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= RESET_WAIT;
      clrCnt_q <= '0;
      rdPipe_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
      rdPipe_q <= rdPipe_d;
    end
  end

  // Response FIFO and read credits; a read stays charged until its response is popped.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem_q[i] <= '0;
      end
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fillCnt_q <= '0;
      credit_q  <= '0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= RdData_DI;
        wrPtr_q <= (wrPtr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_q <= (rdPtr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fillCnt_q <= fillCnt_q + CRED_W'(1);
        2'b01:   fillCnt_q <= fillCnt_q - CRED_W'(1);
        default: fillCnt_q <= fillCnt_q;
      endcase
      case ({readAccept, pop})
        2'b10:   credit_q <= credit_q + CRED_W'(1);
        2'b01:   credit_q <= credit_q - CRED_W'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_sp_ram_ctrl_nx64.sv
// Directed bench for sync_sp_ram_ctrl_nx64 (16 words, RAM latency 2, zero-fill on)
// with a behavioural byte-enable RAM and an expected-response queue.
module tb_sync_sp_ram_ctrl_nx64;

  localparam int AW  = 4;
  localparam int LAT = 2;

  logic        Clk_CI = 1'b0;
  logic        Rst_RBI = 1'b0;
  logic        ReqValid_SI = 1'b0, ReqWrEn_SI = 1'b0, RspReady_SI = 1'b0;
  logic [7:0]  ReqBEn_SI = '0;
  logic [AW-1:0] ReqAddr_DI = '0;
  logic [63:0] ReqWrData_DI = '0;
  logic        ReqReady_SO, RspValid_SO, InitDone_SO, CSel_SO, WrEn_SO;
  logic [63:0] RspRdData_DO, WrData_DO, RdData_DI;
  logic [7:0]  BEn_SO;
  logic [AW-1:0] Addr_DO;

  int errorCount = 0;
  int checkCount = 0;
  logic [63:0] expQ [$];

  sync_sp_ram_ctrl_nx64 #(
    .ADDR_WIDTH(AW), .DATA_DEPTH(16), .RAM_LATENCY(LAT), .INIT_ZERO(1'b1)
  ) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .ReqValid_SI(ReqValid_SI), .ReqReady_SO(ReqReady_SO), .ReqWrEn_SI(ReqWrEn_SI),
    .ReqBEn_SI(ReqBEn_SI), .ReqAddr_DI(ReqAddr_DI), .ReqWrData_DI(ReqWrData_DI),
    .RspValid_SO(RspValid_SO), .RspReady_SI(RspReady_SI), .RspRdData_DO(RspRdData_DO),
    .InitDone_SO(InitDone_SO), .CSel_SO(CSel_SO), .WrEn_SO(WrEn_SO), .BEn_SO(BEn_SO),
    .Addr_DO(Addr_DO), .WrData_DO(WrData_DO), .RdData_DI(RdData_DI)
  );

  always #5 Clk_CI = ~Clk_CI;

  // Behavioural RAM with two read stages (output register enabled).
  logic [63:0] ramMem [16];
  logic [63:0] rdStage1 = '0, rdStage2 = '0;
  always @(posedge Clk_CI) begin
    if (CSel_SO) begin
      if (WrEn_SO) begin
        for (int b = 0; b < 8; b++) begin
          if (BEn_SO[b]) ramMem[Addr_DO][8*b +: 8] <= WrData_DO[8*b +: 8];
        end
      end else begin
        rdStage1 <= ramMem[Addr_DO];
      end
    end
    rdStage2 <= rdStage1;
  end
  assign RdData_DI = rdStage2;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Every popped response is compared against the oldest expected read.
  always @(negedge Clk_CI) begin
    if (Rst_RBI && RspValid_SO && RspReady_SI) begin
      if (expQ.size() == 0) checkOutput("staleRsp", 64'(RspValid_SO), 64'd0);
      else checkOutput("rspData", RspRdData_DO, expQ.pop_front());
    end
  end

  task automatic waitCycle();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] ben,
                               input logic [AW-1:0] addr, input logic [63:0] data);
    int n = 0;
    ReqValid_SI = 1'b1; ReqWrEn_SI = we; ReqBEn_SI = ben;
    ReqAddr_DI = addr; ReqWrData_DI = data;
    while (!ReqReady_SO && n < 50) begin
      waitCycle();
      n++;
    end
    if (!ReqReady_SO) checkOutput("reqTimeout", 64'(ReqReady_SO), 64'd1);
    waitCycle();
    ReqValid_SI = 1'b0; ReqWrEn_SI = 1'b0; ReqBEn_SI = '0;
  endtask

  task automatic drainResponses();
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      waitCycle();
      n++;
    end
    checkOutput("drainLeft", 64'(expQ.size()), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctl"}, 64'({ReqReady_SO, RspValid_SO, InitDone_SO, CSel_SO, WrEn_SO}), 64'd0);
    checkOutput({tag, "_ram"}, 64'({BEn_SO, Addr_DO}) | WrData_DO, 64'd0);
    checkOutput({tag, "_rsp"}, RspRdData_DO, 64'd0);
  endtask

  function automatic logic [63:0] patData(input int a);
    return {16'hC0DE, 12'h000, 4'(a), 16'hBEEF, 12'h000, ~4'(a)};
  endfunction

  initial begin
    int nAcc;
    int n;

    #3;
    checkResetOutputs("rst");
    repeat (3) waitCycle();
    Rst_RBI = 1'b1;
    checkOutput("waitCsel", 64'(CSel_SO), 64'd0);
    for (int i = 0; i < 16; i++) begin
      waitCycle();
      checkOutput("clrCtl", 64'({CSel_SO, WrEn_SO, BEn_SO}), 64'h3FF);
      checkOutput("clrAddr", 64'(Addr_DO), 64'(i));
      checkOutput("clrData", WrData_DO, 64'd0);
      checkOutput("clrDone", 64'({InitDone_SO, ReqReady_SO}), 64'd0);
    end
    waitCycle();
    checkOutput("initDone", 64'({InitDone_SO, ReqReady_SO, CSel_SO}), 64'b110);

    // Byte-enable merge plus read latency with the response held.
    applyStimulus(1'b1, 8'hFF, 4'd5, 64'h0123456789ABCDEF);
    applyStimulus(1'b1, 8'h0F, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    expQ.push_back(64'h01234567FFFFFFFF);
    applyStimulus(1'b0, 8'h00, 4'd5, 64'd0);
    checkOutput("lat0", 64'(RspValid_SO), 64'd0);
    waitCycle();
    checkOutput("lat1", 64'(RspValid_SO), 64'd0);
    waitCycle();
    checkOutput("lat2", 64'(RspValid_SO), 64'd1);
    checkOutput("latData", RspRdData_DO, 64'h01234567FFFFFFFF);
    RspReady_SI = 1'b1;
    drainResponses();

    // Write then read on consecutive cycles, and a zero-filled word.
    applyStimulus(1'b1, 8'hFF, 4'd9, 64'hDEAD_BEEF_CAFE_F00D);
    expQ.push_back(64'hDEAD_BEEF_CAFE_F00D);
    applyStimulus(1'b0, 8'h00, 4'd9, 64'd0);
    expQ.push_back(64'd0);
    applyStimulus(1'b0, 8'h00, 4'd3, 64'd0);
    drainResponses();

    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 8'hFF, 4'(a), patData(a));

    // 32 back-to-back reads with the response side always ready.
    ReqValid_SI = 1'b1; ReqWrEn_SI = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReqAddr_DI = 4'(i % 16);
      expQ.push_back(patData(i % 16));
      checkOutput("streamRdy", 64'(ReqReady_SO), 64'd1);
      waitCycle();
    end
    ReqValid_SI = 1'b0;
    drainResponses();

    // Backpressure: only LAT+2 reads fit before ready drops.
    RspReady_SI = 1'b0;
    ReqValid_SI = 1'b1; ReqWrEn_SI = 1'b0;
    nAcc = 0;
    for (int c = 0; c < 10; c++) begin
      logic rdyNow;
      rdyNow = ReqReady_SO;
      ReqAddr_DI = 4'(nAcc + 1);
      waitCycle();
      if (rdyNow) begin
        expQ.push_back(patData(nAcc + 1));
        nAcc++;
      end
    end
    ReqValid_SI = 1'b0;
    checkOutput("bpAccepted", 64'(nAcc), 64'(LAT + 2));
    checkOutput("bpReady", 64'(ReqReady_SO), 64'd0);
    checkOutput("bpValid", 64'(RspValid_SO), 64'd1);
    checkOutput("bpHead", RspRdData_DO, patData(1));
    repeat (2) waitCycle();
    checkOutput("bpHold", RspRdData_DO, patData(1));
    RspReady_SI = 1'b1;
    waitCycle();
    checkOutput("bpReopen", 64'(ReqReady_SO), 64'd1);
    drainResponses();

    // Reset with two reads in flight, then again mid-clear at C=7.
    RspReady_SI = 1'b0;
    applyStimulus(1'b0, 8'h00, 4'd6, 64'd0);
    applyStimulus(1'b0, 8'h00, 4'd7, 64'd0);
    #2;
    Rst_RBI = 1'b0;
    #1;
    checkResetOutputs("rstRun");
    expQ.delete();
    RspReady_SI = 1'b1;
    waitCycle();
    Rst_RBI = 1'b1;
    repeat (8) waitCycle();
    checkOutput("midClrAddr", 64'(Addr_DO), 64'd7);
    #2;
    Rst_RBI = 1'b0;
    #1;
    checkResetOutputs("rstClr");
    waitCycle();
    Rst_RBI = 1'b1;
    waitCycle();
    checkOutput("restartCsel", 64'(CSel_SO), 64'd1);
    checkOutput("restartAddr", 64'(Addr_DO), 64'd0);
    n = 0;
    while (!InitDone_SO && n < 100) begin
      waitCycle();
      n++;
    end
    checkOutput("initDone2", 64'(InitDone_SO), 64'd1);
    expQ.push_back(64'd0);
    applyStimulus(1'b0, 8'h00, 4'd6, 64'd0);
    drainResponses();
    repeat (5) waitCycle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
